// File: rtl/fmps_test_pkg.sv
// Shared definitions for the FMPS test packet generator: header magic,
// data-word field positions, fault-injection encodings and FSM states.
package fmps_test_pkg;

  localparam logic [15:0] MAGIC_DEFAULT = 16'hB6CF;

  // Data word field positions
  localparam int INV_HI   = 31;
  localparam int INV_LO   = 30;
  localparam int RSVD_BIT = 29;
  localparam int IDX_HI   = 28;
  localparam int IDX_LO   = 24;
  localparam int PAT_HI   = 23;
  localparam int PAT_LO   = 8;
  localparam int CYC_HI   = 7;
  localparam int CYC_LO   = 0;

  typedef enum logic [1:0] {
    INJ_NONE      = 2'd0,
    INJ_BAD_MAGIC = 2'd1,
    INJ_INVALID   = 2'd2,
    INJ_SHORT     = 2'd3
  } inject_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

endpackage

// File: rtl/fmps_req_queue.sv
// Pending-request counter with FA flush, full/overflow detection and the
// saturating dropped-packet counter shared with the framing FSM.
module fmps_req_queue #(
  parameter int MAX_PENDING = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req,
  input  logic                               deq,
  input  logic                               flush,
  input  logic                               chan_up,
  input  logic                               abort,
  input  logic                               clear,
  output logic [$clog2(MAX_PENDING+1)-1:0]   count,
  output logic [15:0]                        dropped,
  output logic                               overflow
);

  localparam int CW = $clog2(MAX_PENDING + 1);

  logic        full;
  logic        full_drop;
  logic        drop_ev;
  logic [16:0] drop_sum;

  assign full      = (count == CW'(MAX_PENDING));
  // A flush empties the queue, so a coincident request always fits.
  assign full_drop = req && chan_up && full && !flush;
  assign drop_ev   = (req && !chan_up) || full_drop;
  assign drop_sum  = {1'b0, dropped} + 17'(drop_ev) + 17'(abort);

  // Pending count: channel-down clear, FA flush, then normal enqueue/dequeue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!chan_up) begin
      count <= '0;
    end else if (flush) begin
      count <= CW'(req);
    end else if ((req && !full) && !(deq && count != '0)) begin
      count <= count + 1'b1;
    end else if (!(req && !full) && (deq && count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Status: clear wins over same-cycle events; dropped count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      dropped  <= '0;
      overflow <= 1'b0;
    end else begin
      dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (full_drop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/fmps_test_packet_gen.sv
// FMPS test-traffic generator: frames queued requests into header+data
// packets on the Aurora TX AXI-Stream, with fault injection and link-drop
// accounting.
//
// state     | meaning
// ST_IDLE   | no word presented; launch a header when a request is queued
// ST_HEADER | header presented, waiting for tready
// ST_DATA   | data word word_idx presented, waiting for tready
module fmps_test_packet_gen
  import fmps_test_pkg::*;
#(
  parameter int          INDEX_WIDTH     = 5,
  parameter int          INDEX_START_BIT = 10,
  parameter logic [15:0] MAGIC           = MAGIC_DEFAULT,
  parameter int          NUM_DATA_WORDS  = 1,
  parameter logic [15:0] DATA_PATTERN    = 16'hCACA,
  parameter int          MAX_PENDING     = 8
) (
  input  logic                             auroraUserClk,
  input  logic                             auroraResetN,
  input  logic                             auroraFAstrobe,
  input  logic                             genPacketStrobe,
  input  logic                             auroraChannelUp,
  input  logic [INDEX_WIDTH-1:0]           baseIndex,
  input  logic [1:0]                       injectMode,
  input  logic                             clearStatus,
  output logic [31:0]                      TX_tdata,
  output logic                             TX_tvalid,
  output logic                             TX_tlast,
  input  logic                             TX_tready,
  output logic [$clog2(MAX_PENDING+1)-1:0] pendingCount,
  output logic [15:0]                      droppedCount,
  output logic                             overflow
);

  state_t                 state, state_d;
  inject_t                mode, mode_d;
  logic [INDEX_WIDTH-1:0] pkt_num, pkt_num_d, idx, idx_d;
  logic [7:0]             cycle_counter, cyc_lat, cyc_lat_d;
  logic [4:0]             word_idx, word_idx_d;
  logic [31:0]            tdata_d;
  logic                   tvalid_d, tlast_d;
  logic                   deq, abort;

  function automatic logic [31:0] header_word(logic [INDEX_WIDTH-1:0] i, inject_t m);
    logic [31:0] h;
    h = {(m == INJ_BAD_MAGIC) ? ~MAGIC : MAGIC, 16'h0000};
    h[INDEX_START_BIT +: INDEX_WIDTH] = i;
    return h;
  endfunction

  function automatic logic [31:0] data_word(logic [4:0] w, logic [INDEX_WIDTH-1:0] i,
                                            inject_t m, logic [7:0] c);
    logic [31:0] d;
    d                 = '0;
    d[INV_HI:INV_LO]  = (m == INJ_INVALID) ? 2'b11 : 2'b00;
    d[RSVD_BIT]       = 1'b0;
    d[IDX_HI:IDX_LO]  = 5'(i);
    d[PAT_HI:PAT_LO]  = DATA_PATTERN + 16'(w);
    d[CYC_HI:CYC_LO]  = c;
    return d;
  endfunction

  function automatic logic is_last(logic [4:0] w, inject_t m);
    return (w == 5'(NUM_DATA_WORDS - 1)) || ((w == 5'd0) && (m == INJ_SHORT));
  endfunction

  fmps_req_queue #(.MAX_PENDING(MAX_PENDING)) u_queue (
    .clk      (auroraUserClk),
    .rst_n    (auroraResetN),
    .req      (genPacketStrobe),
    .deq      (deq),
    .flush    (auroraFAstrobe),
    .chan_up  (auroraChannelUp),
    .abort    (abort),
    .clear    (clearStatus),
    .count    (pendingCount),
    .dropped  (droppedCount),
    .overflow (overflow)
  );

  // FA cycle counter, first strobe reads 1, wraps naturally
  always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
    if (!auroraResetN) cycle_counter <= '0;
    else if (auroraFAstrobe) cycle_counter <= cycle_counter + 8'd1;
  end

  // Next-state and registered-output logic; stream outputs only change on
  // launch, acceptance or abort, so they hold while stalled
  always_comb begin
    state_d    = state;
    mode_d     = mode;
    pkt_num_d  = pkt_num;
    idx_d      = idx;
    cyc_lat_d  = cyc_lat;
    word_idx_d = word_idx;
    tdata_d    = TX_tdata;
    tvalid_d   = TX_tvalid;
    tlast_d    = TX_tlast;
    deq        = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        if (pendingCount != '0 && auroraChannelUp) begin
          idx_d    = baseIndex + (auroraFAstrobe ? '0 : pkt_num);
          mode_d   = inject_t'(injectMode);
          tdata_d  = header_word(idx_d, mode_d);
          tvalid_d = 1'b1;
          state_d  = ST_HEADER;
        end
      end
      ST_HEADER, ST_DATA: begin
        if (!auroraChannelUp) begin
          abort    = 1'b1;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          state_d  = ST_IDLE;
        end else if (TX_tready) begin
          if (state == ST_HEADER) begin
            deq        = 1'b1;
            pkt_num_d  = pkt_num + 1'b1;
            cyc_lat_d  = cycle_counter;
            word_idx_d = 5'd0;
            tdata_d    = data_word(5'd0, idx, mode, cycle_counter);
            tlast_d    = is_last(5'd0, mode);
            state_d    = ST_DATA;
          end else if (TX_tlast) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            word_idx_d = word_idx + 5'd1;
            tdata_d    = data_word(word_idx_d, idx, mode, cyc_lat);
            tlast_d    = is_last(word_idx_d, mode);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (auroraFAstrobe) pkt_num_d = '0;
  end

  // State and datapath registers
  always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      state     <= ST_IDLE;
      mode      <= INJ_NONE;
      pkt_num   <= '0;
      idx       <= '0;
      cyc_lat   <= '0;
      word_idx  <= '0;
      TX_tdata  <= '0;
      TX_tvalid <= 1'b0;
      TX_tlast  <= 1'b0;
    end else begin
      state     <= state_d;
      mode      <= mode_d;
      pkt_num   <= pkt_num_d;
      idx       <= idx_d;
      cyc_lat   <= cyc_lat_d;
      word_idx  <= word_idx_d;
      TX_tdata  <= tdata_d;
      TX_tvalid <= tvalid_d;
      TX_tlast  <= tlast_d;
    end
  end

endmodule

// File: tb/tb_fmps_test_packet_gen.sv
// Scoreboard bench for fmps_test_packet_gen with two data words per packet.
module tb_fmps_test_packet_gen;

  localparam int NW = 2;

  logic        clk;
  logic        rst_n;
  logic        fa;
  logic        gen;
  logic        chan;
  logic [4:0]  base;
  logic [1:0]  inj;
  logic        clr;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [3:0]  pending;
  logic [15:0] dropped;
  logic        ovf;

  int          checks;
  int          errors;
  logic [32:0] exp_q[$];
  logic [7:0]  m_cyc;
  logic [4:0]  m_pnum;
  int          ready_mode;
  logic        stall_prev;
  logic [32:0] stall_word;

  fmps_test_packet_gen #(.NUM_DATA_WORDS(NW)) dut (
    .auroraUserClk   (clk),
    .auroraResetN    (rst_n),
    .auroraFAstrobe  (fa),
    .genPacketStrobe (gen),
    .auroraChannelUp (chan),
    .baseIndex       (base),
    .injectMode      (inj),
    .clearStatus     (clr),
    .TX_tdata        (tdata),
    .TX_tvalid       (tvalid),
    .TX_tlast        (tlast),
    .TX_tready       (tready),
    .pendingCount    (pending),
    .droppedCount    (dropped),
    .overflow        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [1:0] mode, input logic [7:0] cyc);
    logic [4:0]  idx;
    logic [31:0] h;
    logic [31:0] d;
    logic        last;
    idx    = base + m_pnum;
    m_pnum = m_pnum + 5'd1;
    h = {(mode == 2'd1) ? ~16'hB6CF : 16'hB6CF, 16'h0000} | (32'(idx) << 10);
    exp_q.push_back({1'b0, h});
    for (int w = 0; w < NW; w++) begin
      d    = {(mode == 2'd2) ? 2'b11 : 2'b00, 1'b0, idx, 16'hCACA + 16'(w), cyc};
      last = (w == NW - 1) || (mode == 2'd3);
      exp_q.push_back({last, d});
      if (last) break;
    end
  endtask

  task automatic request();
    gen = 1'b1;
    tick();
    gen = 1'b0;
  endtask

  task automatic fa_pulse(input logic with_req);
    m_cyc  = m_cyc + 8'd1;
    m_pnum = '0;
    if (with_req) push_pkt(2'd0, m_cyc);
    fa  = 1'b1;
    gen = with_req;
    tick();
    fa  = 1'b0;
    gen = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_done", 64'(n < 3000), 64'd1);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0; fa = 1'b0; gen = 1'b0; chan = 1'b0; clr = 1'b0;
    base = 5'd1; inj = 2'd0; tready = 1'b0; ready_mode = 1;
    m_cyc = '0; m_pnum = '0; stall_prev = 1'b0; stall_word = '0;

    fork
      begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
      begin : ready_drv
        forever begin
          @(posedge clk);
          #2;
          case (ready_mode)
            0:       tready = 1'b0;
            1:       tready = 1'b1;
            default: tready = 1'($urandom_range(0, 1));
          endcase
        end
      end
      begin : monitor
        logic [32:0] e;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            stall_prev = 1'b0;
          end else begin
            if (stall_prev && tvalid) check("stall_stable", 64'({tlast, tdata}), 64'(stall_word));
            if (tvalid && tready) begin
              check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
              if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tdata", 64'(tdata), 64'(e[31:0]));
                check("tlast", 64'(tlast), 64'(e[32]));
              end
            end
            stall_prev = tvalid && !tready;
            stall_word = {tlast, tdata};
          end
        end
      end
    join_none

    // Reset values
    repeat (3) tick();
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_dropped", 64'(dropped), 64'd0);
    check("rst_overflow", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    chan  = 1'b1;
    tick();

    // Single packet: B6CF0400, 01CACA01, 01CACB01(last)
    fa_pulse(1'b0);
    push_pkt(2'd0, m_cyc);
    request();
    drain();
    check("t1_pending", 64'(pending), 64'd0);

    // Eight spaced requests under random backpressure
    fa_pulse(1'b0);
    ready_mode = 2;
    for (int i = 0; i < 8; i++) begin
      push_pkt(2'd0, m_cyc);
      request();
      repeat (7) tick();
    end
    drain();
    ready_mode = 1;
    tick();
    check("t2_dropped", 64'(dropped), 64'd0);
    check("t2_overflow", 64'(ovf), 64'd0);
    check("t2_pending", 64'(pending), 64'd0);

    // Overflow: 10 back-to-back requests with sink stalled
    fa_pulse(1'b0);
    ready_mode = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) push_pkt(2'd0, m_cyc);
      request();
    end
    tick();
    check("ovf_pending", 64'(pending), 64'd8);
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_dropped", 64'(dropped), 64'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_dropped", 64'(dropped), 64'd0);
    check("clr_overflow", 64'(ovf), 64'd0);
    check("clr_pending", 64'(pending), 64'd8);
    ready_mode = 1;
    drain();
    check("ovf_drained", 64'(pending), 64'd0);

    // Fault injection modes 1..3
    fa_pulse(1'b0);
    for (int m = 1; m < 4; m++) begin
      inj = 2'(m);
      push_pkt(2'(m), m_cyc);
      request();
      drain();
    end
    inj = 2'd0;

    // Channel drop while the second data word is presented
    fa_pulse(1'b0);
    push_pkt(2'd0, m_cyc);
    void'(exp_q.pop_back());
    request();
    request();
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drop_setup", 64'(n < 200), 64'd1);
    check("drop_pre_pending", 64'(pending), 64'd1);
    chan = 1'b0;
    ready_mode = 0;
    tick();
    check("drop_tvalid", 64'(tvalid), 64'd0);
    check("drop_dropped", 64'(dropped), 64'd1);
    check("drop_pending", 64'(pending), 64'd0);
    request();
    tick();
    check("down_req_dropped", 64'(dropped), 64'd2);
    check("down_req_pending", 64'(pending), 64'd0);
    chan = 1'b1;
    tick();

    // Asynchronous reset with a header stalled on the bus
    request();
    n = 0;
    while (!tvalid && n < 50) begin
      tick();
      n++;
    end
    check("arst_hdr_up", 64'(tvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(tvalid), 64'd0);
    check("arst_tdata", 64'(tdata), 64'd0);
    check("arst_tlast", 64'(tlast), 64'd0);
    check("arst_pending", 64'(pending), 64'd0);
    check("arst_dropped", 64'(dropped), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    m_cyc = '0;
    m_pnum = '0;
    ready_mode = 1;
    tick();

    // FA flush of queued requests; the stalled packet still completes
    fa_pulse(1'b0);
    ready_mode = 0;
    push_pkt(2'd0, m_cyc + 8'd1);
    request();
    request();
    request();
    check("flush_pre", 64'(pending), 64'd3);
    fa_pulse(1'b0);
    check("flush_post", 64'(pending), 64'd0);
    ready_mode = 1;
    drain();

    // FA coincident with a request, index wrap from baseIndex=30
    base = 5'd30;
    ready_mode = 0;
    fa_pulse(1'b1);
    check("fa_req_pending", 64'(pending), 64'd1);
    push_pkt(2'd0, m_cyc);
    push_pkt(2'd0, m_cyc);
    request();
    request();
    ready_mode = 1;
    drain();
    check("wrap_pending", 64'(pending), 64'd0);

    // Cycle counter wrap 255 -> 0
    base = 5'd1;
    while (m_cyc != 8'hFF) fa_pulse(1'b0);
    fa_pulse(1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
